addr_sweep_gen: RTL and testbench

ADDR_SWEEP_GEN -- requirements
Module: addr_sweep_gen

---
 rtl/addr_sweep_gen.sv | 113 +++++++++++
 tb/tb_addr_sweep_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/addr_sweep_gen.sv
// Interleaved multi-lane address sweep generator with ready/valid handshake.
// Optional build macro ADDR_SWEEP_WRAP_EN honours the wrap input for continuous sweeps.
module addr_sweep_gen #(
  parameter int ADDR_W = 14,
  parameter int LANES  = 2,
  parameter int LEN_W  = 14,
  localparam int LB    = $clog2(LANES),
  localparam int IW    = ADDR_W - LB
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      wrap,
  input  logic [IW-1:0]             base_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic                      ready,
  output logic [LANES*ADDR_W-1:0]   addr,
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | presenting address sets, advancing on ready
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [LEN_W-1:0] rem;
  logic [IW-1:0]    base_q;
  logic [LEN_W-1:0] len_q;
  logic             wrap_eff;

`ifdef ADDR_SWEEP_WRAP_EN
  assign wrap_eff = wrap;
`else
  assign wrap_eff = wrap & 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      rem    <= '0;
      base_q <= '0;
      len_q  <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            base_q <= base_i;
            len_q  <= len_i;
            busy   <= 1'b1;
            if (len_i == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= base_i;
              rem   <= len_i;
              valid <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          // abort takes priority over any transfer in the same cycle
          if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (ready) begin
            if (rem > LEN_W'(1)) begin
              idx <= idx + IW'(1);
              rem <= rem - LEN_W'(1);
            end else if (wrap_eff) begin
              idx <= base_q;
              rem <= len_q;
            end else begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Lane k carries {idx, k}; the bus is forced to zero whenever valid is low.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [LB-1:0] KL = LB'(k);
    assign addr[k*ADDR_W +: ADDR_W] = valid ? {idx, KL} : '0;
  end

endmodule

// File: tb/tb_addr_sweep_gen.sv
// Self-checking bench for addr_sweep_gen: directed corner cases plus randomized sweeps
// compared against an arithmetic reference model.
module tb_addr_sweep_gen;

  localparam int IW0 = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, wrap, ready;
  logic [12:0] base_i;
  logic [13:0] len_i;
  logic [27:0] addr;
  logic        valid, busy, done;

  logic        start1, abort1, wrap1, ready1;
  logic [5:0]  base1;
  logic [13:0] len1;
  logic [31:0] addr1;
  logic        valid1, busy1, done1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  addr_sweep_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .wrap(wrap),
    .base_i(base_i), .len_i(len_i), .ready(ready),
    .addr(addr), .valid(valid), .busy(busy), .done(done)
  );

  addr_sweep_gen #(.ADDR_W(8), .LANES(4), .LEN_W(14)) dut4 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .wrap(wrap1),
    .base_i(base1), .len_i(len1), .ready(ready1),
    .addr(addr1), .valid(valid1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: two lanes, lane k address = 2*idx + k.
  function automatic logic [27:0] exp_addr(input int idx);
    logic [27:0] r;
    r[13:0]  = 14'(2 * idx);
    r[27:14] = 14'(2 * idx + 1);
    return r;
  endfunction

  task automatic sweep(input int base, input int len, input int stall_lo, input int stall_hi,
                       input bit rnd, input int exp_done_cyc);
    int  xfers = 0;
    int  cyc = 0;
    int  budget = len * 20 + 20;
    bit  fin = 0;
    bit  rdy;
    int  idx;
    @(negedge clk);
    start = 1; abort = 0; wrap = 0; ready = 1;
    base_i = 13'(base); len_i = 14'(len);
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      // latched values and start must be ignored from here on
      start = 1'($urandom_range(0, 1));
      base_i = 13'($urandom);
      len_i = 14'($urandom);
      if (xfers < len) begin
        idx = (base + xfers) % (1 << IW0);
        chk("run_valid", valid, 1);
        chk("run_addr", addr, exp_addr(idx));
        chk("run_done_low", done, 0);
        rdy = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
        ready = rdy;
        if (rdy) xfers++;
      end else begin
        chk("done_pulse", done, 1);
        chk("done_valid_low", valid, 0);
        chk("done_busy", busy, 1);
        if (exp_done_cyc > 0) chk("done_cycle", cyc, exp_done_cyc);
        fin = 1;
      end
    end
    if (!fin) chk("sweep_timeout", 0, 1);
    @(negedge clk);
    start = 0; ready = 1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_valid", valid, 0);
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; wrap = 0; ready = 1; base_i = '0; len_i = '0;
    start1 = 0; abort1 = 0; wrap1 = 0; ready1 = 1; base1 = '0; len1 = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;

    // long sweep, then the same with a stall
    sweep(3584, 128, 0, -1, 0, 129);
    sweep(3584, 128, 5, 9, 0, 134);

    // zero-length sweep
    sweep(77, 0, 0, -1, 0, 1);

    // four-lane instance with index wrap
    @(negedge clk);
    start1 = 1; base1 = 6'd62; len1 = 14'd3;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start1 = 0;
      chk("l4_valid", valid1, 1);
      chk("l4_lane0", addr1[7:0], (c == 1) ? 248 : (c == 2) ? 252 : 0);
      chk("l4_lane3", addr1[31:24], (c == 1) ? 251 : (c == 2) ? 255 : 3);
    end
    @(negedge clk);
    chk("l4_done", done1, 1);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1; abort = 1; base_i = 13'd5; len_i = 14'd4;
    @(negedge clk);
    start = 0; abort = 0;
    chk("sa_busy", busy, 0);
    chk("sa_valid", valid, 0);

    // abort at the third valid cycle, with a transfer in that cycle
    @(negedge clk);
    start = 1; base_i = 13'd100; len_i = 14'd10; ready = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 0;
      chk("ab_valid", valid, 1);
      chk("ab_addr", addr, exp_addr(100 + c - 1));
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("ab_valid_off", valid, 0);
    chk("ab_busy_off", busy, 0);
    chk("ab_no_done", done, 0);
    @(negedge clk);
    chk("ab_no_done2", done, 0);

    // reset in the middle of a sweep
    start = 1; base_i = 13'd200; len_i = 14'd20;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("rs_pre_valid", valid, 1);
    #1 reset = 1;
    #1;
    chk("rs_addr", addr, 0);
    chk("rs_valid", valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    @(negedge clk);
    reset = 0;
    chk("rs_hold_valid", valid, 0);
    @(negedge clk);
    chk("rs_no_done", done, 0);
    sweep(8190, 5, 0, -1, 0, 6);

    // wrap behaviour
    @(negedge clk);
    start = 1; wrap = 1; base_i = 13'd10; len_i = 14'd2; ready = 1;
`ifdef ADDR_SWEEP_WRAP_EN
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      chk("wr_valid", valid, 1);
      chk("wr_lane0", addr[13:0], (c % 2 == 1) ? 20 : 22);
      if (c == 6) wrap = 0;
    end
    @(negedge clk);
    chk("wr_done", done, 1);
`else
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      start = 0;
      chk("nw_valid", valid, 1);
      chk("nw_lane0", addr[13:0], (c == 1) ? 20 : 22);
    end
    @(negedge clk);
    chk("nw_done", done, 1);
    chk("nw_valid_off", valid, 0);
`endif
    wrap = 0;
    @(negedge clk);

    // randomized sweeps with random backpressure
    for (int t = 0; t < 8; t++) begin
      int b, l;
      b = (t % 3 == 0) ? (8191 - int'($urandom_range(0, 4))) : int'($urandom_range(0, 8191));
      l = int'($urandom_range(0, 40));
      sweep(b, l, 0, -1, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
